divu4_seq: RTL and testbench
============================

DIVU4_SEQ -- requirements
Module: divu4_seq

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL provide port: start  input  1  request to begin a division; sampled only when idle or done.
REQ-004 SHALL provide port: A  input  4  unsigned dividend; captured on accepted start.
REQ-005 SHALL provide port: B  input  4  unsigned divisor; captured on accepted start.
REQ-006 SHALL provide port: busy  output  1  high while a division is in progress.
REQ-007 SHALL provide port: done  output  1  one-cycle pulse; Q and R are valid.
REQ-008 SHALL provide port: Q  output  4  unsigned quotient.
REQ-009 SHALL provide port: R  output  4  unsigned remainder.
REQ-010 SHALL provide port: Dbz  output  1  divide-by-zero flag; present only when DIVU4_DBZ_EN is defined.

Function
REQ-011 SHALL implement a restoring divider using a 5-bit partial remainder and a 4-bit subtract, one quotient bit per cycle, MSB first.
- Per iteration: shift the next dividend bit into the remainder, then compute remainder minus {0,B}.
- If the result is non-negative, keep it and set the quotient bit to 1.
- Otherwise, restore the remainder and set the quotient bit to 0.
REQ-012 SHALL use the FSM states IDLE, RUN, DONE.
- IDLE: on start=1, go to RUN.
- RUN: after 4 iterations, go to DONE.
- DONE: after one cycle, go to IDLE, or to RUN if start=1.
REQ-013 SHALL capture A and B and clear the iteration count on the edge that accepts start; later changes to A/B have no effect until the next accepted start.
REQ-014 SHALL take 4 cycles from acceptance to result: start accepted at edge k, iterations at edges k+1..k+4, done=1 in the cycle following edge k+4.
REQ-015 SHALL drive busy=1 from the accepting edge until the edge that raises done; busy=0 in IDLE and DONE.
REQ-016 SHALL ignore start while busy=1; the in-progress operation SHALL complete unaffected.
REQ-017 SHALL accept start during the DONE cycle (back-to-back operation); done SHALL then drop and busy rise on the next edge.
REQ-018 SHALL hold Q and R stable from done until the edge that delivers the next result; intermediate values SHALL NOT be visible on Q/R.
REQ-019 SHALL satisfy A = Q*B + R with R < B for every B != 0.
REQ-020 SHALL produce Q=4'hF and R=A when B=0.

Reset
REQ-021 SHALL, when rst=1 at a clock edge, force state=IDLE, busy=0, done=0, Q=0, R=0, Dbz=0 (if present).
REQ-022 SHALL let rst take priority over start and over any in-progress RUN; the aborted operation SHALL produce no done pulse.
REQ-023 SHALL accept start on the first edge after rst deasserts.

Configuration
REQ-024 SHALL recognise the macro DIVU4_DBZ_EN.
- Defined: Dbz port is present. An accepted start with B=0 goes directly to DONE: done=1 one cycle after the accepting edge, Q=4'hF, R=A, Dbz=1. Dbz clears at the next accepted start or reset.
- Undefined: Dbz port is absent. B=0 runs the normal 4-cycle RUN sequence and yields Q=4'hF, R=A naturally.

Verification
REQ-025 SHALL cover: A=13, B=3, start pulsed at edge k -> busy high edges k..k+4, done=1 after edge k+4, Q=4, R=1.
REQ-026 SHALL cover: A=15, B=1 -> Q=15, R=0; then A=5, B=7 started in the DONE cycle -> Q=0, R=5 four cycles later, no idle gap.
REQ-027 SHALL cover: start during RUN with A=2, B=1 -> ignored; original result delivered on time; no second done pulse.
REQ-028 SHALL cover: A=9, B=0 -> with DIVU4_DBZ_EN, done one cycle after accept, Q=15, R=9, Dbz=1; without it, done after 4 cycles, Q=15, R=9.
REQ-029 SHALL cover: rst asserted at the second RUN cycle -> next edge busy=0, done=0, Q=0, R=0; a new start accepted immediately after gives a correct result.
REQ-030 SHALL cover: exhaustive sweep of all 256 A/B pairs against a reference model -> REQ-019 and REQ-020 hold.

Source files
------------

// File: rtl/divu4_seq.sv
// divu4_seq: sequential 4-bit unsigned restoring divider, one quotient bit per cycle.
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a division (accepted only in IDLE or DONE)
//   A      in   4-bit dividend, captured on accepted start
//   B      in   4-bit divisor, captured on accepted start
//   busy   out  high while a division is running
//   done   out  one-cycle pulse, Q/R valid
//   Q      out  4-bit quotient (held until the next result)
//   R      out  4-bit remainder (held until the next result)
//   Dbz    out  divide-by-zero flag, only when DIVU4_DBZ_EN is defined
//
// Configuration macro: DIVU4_DBZ_EN
//   defined   - B=0 skips the iteration sequence, finishes one cycle after accept
//               with Q=4'hF, R=A and raises Dbz.
//   undefined - no Dbz port; B=0 runs the normal sequence and yields Q=4'hF, R=A.
module divu4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] Q,
  output logic [3:0] R
`ifdef DIVU4_DBZ_EN
  ,
  output logic       Dbz
`endif
);

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic          busy_next;
  logic          done_next;

  logic [W-1:0]  a_sh;      // dividend, shifted left as bits enter the remainder
  logic [W-1:0]  b_reg;     // captured divisor
  logic [W-1:0]  rem;       // partial remainder, always < B (or a prefix of A when B=0)
  logic [W-1:0]  quo;       // quotient bits collected so far
  logic [CW-1:0] cnt;       // iteration index

  logic [W:0]    rem_sh;
  logic          q_bit;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quo_next;
  logic          last_iter;
  logic          accept;
  logic          take_dbz;

  // Start is only honoured when no division is in flight.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CW'(W - 1));

`ifdef DIVU4_DBZ_EN
  assign take_dbz = (B == '0);
`else
  assign take_dbz = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract {0,B}.
  always_comb begin
    rem_sh   = {rem, a_sh[W-1]};
    q_bit    = (rem_sh >= {1'b0, b_reg});
    rem_next = q_bit ? W'(rem_sh - {1'b0, b_reg}) : rem_sh[W-1:0];
    quo_next = {quo[W-2:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = take_dbz ? DONE : RUN;
      end
      RUN: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = take_dbz ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode, registered below so busy/done line up with the state.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    if (state_next == RUN)  busy_next = 1'b1;
    if (state_next == DONE) done_next = 1'b1;
  end

  // Status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Datapath: operand capture, iteration, and result registers.
  // Q/R only change when a result is delivered, so partial values stay hidden.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_reg <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
    end else if (accept) begin
      a_sh  <= A;
      b_reg <= B;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      if (take_dbz) begin
        Q <= '1;
        R <= A;
      end
    end else if (state == RUN) begin
      a_sh <= {a_sh[W-2:0], 1'b0};
      rem  <= rem_next;
      quo  <= quo_next;
      cnt  <= cnt + CW'(1);
      if (last_iter) begin
        Q <= quo_next;
        R <= rem_next;
      end
    end
  end

`ifdef DIVU4_DBZ_EN
  // Divide-by-zero flag: follows the divisor of each accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      Dbz <= 1'b0;
    end else if (accept) begin
      Dbz <= take_dbz;
    end
  end
`endif

endmodule

// File: tb/tb_divu4_seq.sv
// tb_divu4_seq: directed and table-driven bench for divu4_seq.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_divu4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] R;
`ifdef DIVU4_DBZ_EN
  logic       Dbz;
`endif

  int total  = 0;
  int passed = 0;

  divu4_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R)
`ifdef DIVU4_DBZ_EN
    ,
    .Dbz   (Dbz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Edges between the accepting edge and the edge that raises done.
  function automatic int exp_lat(input logic [3:0] b);
`ifdef DIVU4_DBZ_EN
    if (b == 4'd0) return 0;
`endif
    return 4;
  endfunction

  // Called at a falling edge; starts an operation right away and returns at
  // the falling edge where done is seen (or after the cycle budget runs out).
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input string name);
    int n;
    bit busy_ok;
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 12) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk(n == exp_lat(b), {name, "_lat"}, n, exp_lat(b));
    chk(busy_ok, {name, "_busy_run"}, int'(busy_ok), 1);
    chk(busy === 1'b0, {name, "_busy_done"}, int'(busy), 0);
    chk(Q === eq, {name, "_Q"}, int'(Q), int'(eq));
    chk(R === er, {name, "_R"}, int'(R), int'(er));
`ifdef DIVU4_DBZ_EN
    chk(Dbz === (b == 4'd0), {name, "_Dbz"}, int'(Dbz), int'(b == 4'd0));
`endif
  endtask

  initial begin
    int n;
    bit ok;
    logic [3:0] mq;
    logic [3:0] mr;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0};
    vecs[2] = '{a: 4'd5,  b: 4'd7,  q: 4'd0,  r: 4'd5};
    vecs[3] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9};
    vecs[4] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0};
    vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0};
    vecs[6] = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2};
    vecs[7] = '{a: 4'd7,  b: 4'd2,  q: 4'd3,  r: 4'd1};
    vecs[8] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  r: 4'd2};
    vecs[9] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0};

    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
    repeat (2) @(negedge clk);
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
    chk(done === 1'b0, "rst_done", int'(done), 0);
    chk(Q === 4'd0, "rst_Q", int'(Q), 0);
    chk(R === 4'd0, "rst_R", int'(R), 0);
    rst = 1'b0;

    // Table vectors, each started from IDLE.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Back-to-back: second start issued in the DONE cycle; old result held meanwhile.
    run_op(4'd15, 4'd1, 4'd15, 4'd0, "b2b_first");
    A = 4'd5; B = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(done === 1'b0, "b2b_done_drop", int'(done), 0);
    chk(busy === 1'b1, "b2b_busy_rise", int'(busy), 1);
    n = 0; ok = 1'b1;
    while (!done && n < 12) begin
      if (Q !== 4'd15 || R !== 4'd0) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk(ok, "b2b_hold", int'(ok), 1);
    chk(n == 4, "b2b_lat", n, 4);
    chk(Q === 4'd0, "b2b_Q", int'(Q), 0);
    chk(R === 4'd5, "b2b_R", int'(R), 5);
    repeat (2) @(negedge clk);

    // Start during RUN is ignored; exactly one done pulse.
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd2; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 4'd0; B = 4'd0;
    n = 2;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(n == 4, "ign_lat", n, 4);
    chk(Q === 4'd4, "ign_Q", int'(Q), 4);
    chk(R === 4'd1, "ign_R", int'(R), 1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n++;
    end
    chk(n == 0, "ign_extra_done", n, 0);

    // Reset in the second RUN cycle aborts; a start right after works.
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(busy === 1'b0, "abort_busy", int'(busy), 0);
    chk(done === 1'b0, "abort_done", int'(done), 0);
    chk(Q === 4'd0, "abort_Q", int'(Q), 0);
    chk(R === 4'd0, "abort_R", int'(R), 0);
    rst = 1'b0;
    run_op(4'd7, 4'd2, 4'd3, 4'd1, "post_rst");
    repeat (2) @(negedge clk);

    // Exhaustive sweep against a reference model, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 4'hF;
          mr = 4'(a);
        end else begin
          mq = 4'(a / b);
          mr = 4'(a % b);
        end
        run_op(4'(a), 4'(b), mq, mr, $sformatf("sweep_%0d_%0d", a, b));
      end
    end
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
